data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 18 +
 rtl/data_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, port indices,
// and the two-way round-robin pick used by rr_arbiter2.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;   // CPU
    localparam logic PORT1 = 1'b1;   // debug loader

    // A lone requester wins outright; on a tie the port not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_served);
        if (req0 && req1) begin
            return ~last_served;
        end
        return req1 ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: chooses a winner index from two requests.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req0/req1 requests, last_served port index -> grant index, grant_vld.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant,
    output logic grant_vld
);

    assign grant_vld = req0 | req1;
    assign grant     = rr_pick(req0, req1, last_served);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (port 0) and debug loader (port 1) onto one data memory port.
// Latency: request seen in IDLE -> memory strobe next cycle -> ack the cycle after.
// Backpressure: requests held until ack; back-to-back grants alternate, one per 2 cycles.
// Ports: i_clk, i_reset (sync, active-high); per-port req/we/addr/wdata in,
//        ack/rdata out; o_mem_* strobe/address/data/enables, i_mem_read_data
//        (registered memory data, valid the cycle after a read strobe).
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [RAM_WIDTH-1:0]  i_wdata0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [RAM_WIDTH-1:0]  i_wdata1,
    output logic                  o_ack0,
    output logic [RAM_WIDTH-1:0]  o_rdata0,
    output logic                  o_ack1,
    output logic [RAM_WIDTH-1:0]  o_rdata1,
    output logic                  o_mem_valid,
    output logic [RAM_WIDTH-1:0]  o_mem_address,
    output logic [RAM_WIDTH-1:0]  o_mem_write_data,
    output logic                  o_mem_read_enable,
    output logic                  o_mem_write_enable,
    input  logic [RAM_WIDTH-1:0]  i_mem_read_data
);

    arb_state_t            state_q, state_d;
    logic                  last_served_q;
    logic                  lat_port_q;
    logic                  lat_we_q;
    logic [ADDR_WIDTH-1:0] lat_addr_q;
    logic [RAM_WIDTH-1:0]  lat_wdata_q;
    logic [RAM_WIDTH-1:0]  rdata0_q, rdata1_q;

    logic arb_req0, arb_req1, arb_grant, arb_vld;
    logic grant_en;
    logic resp_rd0, resp_rd1;

    // The port being acked still holds its request this cycle; masking it
    // lets the other port be granted straight into ISSUE with no IDLE gap.
    assign arb_req0 = i_req0 && !(state_q == ST_RESP && lat_port_q == PORT0);
    assign arb_req1 = i_req1 && !(state_q == ST_RESP && lat_port_q == PORT1);

    rr_arbiter2 u_rr (
        .req0        (arb_req0),
        .req1        (arb_req1),
        .last_served (last_served_q),
        .grant       (arb_grant),
        .grant_vld   (arb_vld)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_en           = 1'b0;
        o_ack0             = 1'b0;
        o_ack1             = 1'b0;
        o_mem_valid        = 1'b0;
        o_mem_address      = '0;
        o_mem_write_data   = '0;
        o_mem_read_enable  = 1'b0;
        o_mem_write_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_en = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_mem_valid        = 1'b1;
                o_mem_address      = RAM_WIDTH'(lat_addr_q);
                o_mem_write_data   = lat_wdata_q;
                o_mem_write_enable = lat_we_q;
                o_mem_read_enable  = ~lat_we_q;
                state_d            = ST_RESP;
            end
            ST_RESP: begin
                o_ack0 = (lat_port_q == PORT0);
                o_ack1 = (lat_port_q == PORT1);
                if (arb_vld) begin
                    grant_en = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rd0 = (state_q == ST_RESP) && !lat_we_q && (lat_port_q == PORT0);
    assign resp_rd1 = (state_q == ST_RESP) && !lat_we_q && (lat_port_q == PORT1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_served_q <= PORT1;   // port 0 wins the first tie
            lat_port_q    <= PORT0;
            lat_we_q      <= 1'b0;
            lat_addr_q    <= '0;
            lat_wdata_q   <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            if (grant_en) begin
                last_served_q <= arb_grant;
                lat_port_q    <= arb_grant;
                lat_we_q      <= (arb_grant == PORT1) ? i_we1    : i_we0;
                lat_addr_q    <= (arb_grant == PORT1) ? i_addr1  : i_addr0;
                lat_wdata_q   <= (arb_grant == PORT1) ? i_wdata1 : i_wdata0;
            end
            if (resp_rd0) begin
                rdata0_q <= i_mem_read_data;
            end
            if (resp_rd1) begin
                rdata1_q <= i_mem_read_data;
            end
        end
    end

    // Read data is forwarded in the ack cycle and held by the register afterwards.
    assign o_rdata0 = resp_rd0 ? i_mem_read_data : rdata0_q;
    assign o_rdata1 = resp_rd1 ? i_mem_read_data : rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    typedef struct packed {
        logic        ack0;
        logic        ack1;
        logic        mv;
        logic        mwe;
        logic        mre;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } out_t;

    typedef struct {
        logic        rst, req0, req1, we0, we1;
        logic [9:0]  a0, a1;
        logic [31:0] wd0, wd1;
        out_t        exp;
    } vec_t;

    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic        i_clk, i_reset;
    logic        i_req0, i_we0, i_req1, i_we1;
    logic [9:0]  i_addr0, i_addr1;
    logic [31:0] i_wdata0, i_wdata1;
    logic        o_ack0, o_ack1;
    logic [31:0] o_rdata0, o_rdata1;
    logic        o_mem_valid, o_mem_read_enable, o_mem_write_enable;
    logic [31:0] o_mem_address, o_mem_write_data;
    logic [31:0] i_mem_read_data;

    int checks = 0;
    int failures = 0;

    data_mem_arbiter #(.RAM_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_req0             (i_req0),
        .i_we0              (i_we0),
        .i_addr0            (i_addr0),
        .i_wdata0           (i_wdata0),
        .i_req1             (i_req1),
        .i_we1              (i_we1),
        .i_addr1            (i_addr1),
        .i_wdata1           (i_wdata1),
        .o_ack0             (o_ack0),
        .o_rdata0           (o_rdata0),
        .o_ack1             (o_ack1),
        .o_rdata1           (o_rdata1),
        .o_mem_valid        (o_mem_valid),
        .o_mem_address      (o_mem_address),
        .o_mem_write_data   (o_mem_write_data),
        .o_mem_read_enable  (o_mem_read_enable),
        .o_mem_write_enable (o_mem_write_enable),
        .i_mem_read_data    (i_mem_read_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Data memory: word i initialised to i, registered read data.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        i_mem_read_data = '0;
    end
    always @(posedge i_clk) begin
        if (o_mem_valid && o_mem_read_enable)
            i_mem_read_data <= mem[o_mem_address[9:0]];
        if (o_mem_valid && o_mem_write_enable)
            mem[o_mem_address[9:0]] = o_mem_write_data;
    end

    function automatic vec_t mk(input logic rst, r0, r1, w0, w1,
                                input logic [9:0] a0, a1,
                                input logic [31:0] wd0, wd1,
                                input logic ea0, ea1, emv, emwe, emre,
                                input logic [31:0] emad, emwd, er0, er1);
        vec_t v;
        v.rst = rst; v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1;
        v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
        v.exp = '{ea0, ea1, emv, emwe, emre, emad, emwd, er0, er1};
        return v;
    endfunction

    function automatic out_t observe();
        observe = '{o_ack0, o_ack1, o_mem_valid, o_mem_write_enable,
                    o_mem_read_enable, o_mem_address, o_mem_write_data,
                    o_rdata0, o_rdata1};
    endfunction

    task automatic drive(input vec_t v);
        @(posedge i_clk);
        #1;
        i_reset = v.rst; i_req0 = v.req0; i_req1 = v.req1;
        i_we0 = v.we0; i_we1 = v.we1; i_addr0 = v.a0; i_addr1 = v.a1;
        i_wdata0 = v.wd0; i_wdata1 = v.wd1;
    endtask

    vec_t vq[$];
    out_t got;

    initial begin
        i_reset = 1'b1; i_req0 = 0; i_req1 = 0; i_we0 = 0; i_we1 = 0;
        i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
        repeat (2) @(posedge i_clk);

        //            rst r0 r1 w0 w1 a0 a1 wd0 wd1 | a0 a1 mv we re addr wd rd0 rd1
        vq.push_back(mk(0,0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,  0,0));   // reset state
        vq.push_back(mk(0,1,0,1,0, 5,0, DB,0,  0,0,0,0,0, 0,0,  0,0));   // p0 write req
        vq.push_back(mk(0,1,0,1,0, 5,0, DB,0,  0,0,1,1,0, 5,DB, 0,0));   // issue write
        vq.push_back(mk(0,1,0,1,0, 5,0, DB,0,  1,0,0,0,0, 0,0,  0,0));   // ack0
        vq.push_back(mk(0,0,1,0,0, 0,5, 0,0,   0,0,0,0,0, 0,0,  0,0));   // p1 read req
        vq.push_back(mk(0,0,1,0,0, 0,5, 0,0,   0,0,1,0,1, 5,0,  0,0));
        vq.push_back(mk(0,0,1,0,0, 0,5, 0,0,   0,1,0,0,0, 0,0,  0,DB));  // ack1 + data
        vq.push_back(mk(0,0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,  0,DB));  // held
        vq.push_back(mk(1,0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,  0,DB));  // reset
        vq.push_back(mk(0,1,1,0,0, 3,7, 0,0,   0,0,0,0,0, 0,0,  0,0));   // tie reads
        vq.push_back(mk(0,1,1,0,0, 3,7, 0,0,   0,0,1,0,1, 3,0,  0,0));   // p0 first
        vq.push_back(mk(0,1,1,0,0, 3,7, 0,0,   1,0,0,0,0, 0,0,  3,0));
        vq.push_back(mk(0,0,1,0,0, 3,7, 0,0,   0,0,1,0,1, 7,0,  3,0));   // no idle gap
        vq.push_back(mk(0,0,1,0,0, 3,7, 0,0,   0,1,0,0,0, 0,0,  3,7));
        vq.push_back(mk(0,0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,  3,7));
        vq.push_back(mk(1,0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,  3,7));   // reset
        vq.push_back(mk(0,0,1,0,0, 0,2, 0,0,   0,0,0,0,0, 0,0,  0,0));   // p1 read req
        vq.push_back(mk(1,0,1,0,0, 0,2, 0,0,   0,0,1,0,1, 2,0,  0,0));   // reset in ISSUE
        vq.push_back(mk(0,1,1,0,0, 4,2, 0,0,   0,0,0,0,0, 0,0,  0,0));   // no ack1, idle
        vq.push_back(mk(0,1,1,0,0, 4,2, 0,0,   0,0,1,0,1, 4,0,  0,0));   // p0 wins tie
        vq.push_back(mk(0,1,1,0,0, 4,2, 0,0,   1,0,0,0,0, 0,0,  4,0));
        vq.push_back(mk(0,0,1,0,0, 4,2, 0,0,   0,0,1,0,1, 2,0,  4,0));
        vq.push_back(mk(0,0,1,0,0, 4,2, 0,0,   0,1,0,0,0, 0,0,  4,2));
        vq.push_back(mk(0,0,0,0,0, 0,0, 0,0,   0,0,0,0,0, 0,0,  4,2));
        vq.push_back(mk(0,1,0,0,0, 9,0, 0,0,   0,0,0,0,0, 0,0,  4,2));   // p0 read 9
        vq.push_back(mk(0,1,0,0,0, 9,0, 0,0,   0,0,1,0,1, 9,0,  4,2));
        vq.push_back(mk(0,1,0,0,0, 9,0, 0,0,   1,0,0,0,0, 0,0,  9,2));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0,0,0,0,0, 0,0, 0,0, 0,0,0,0,0, 0,0, 9,2));  // held

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge i_clk);
            got = observe();
            checks++;
            if (got !== vq[i].exp) begin
                failures++;
                $display("FAIL vec%0d got a0=%0b a1=%0b v=%0b we=%0b re=%0b ad=%h wd=%h r0=%h r1=%h exp a0=%0b a1=%0b v=%0b we=%0b re=%0b ad=%h wd=%h r0=%h r1=%h",
                         i, got.ack0, got.ack1, got.mv, got.mwe, got.mre, got.maddr, got.mwd, got.rd0, got.rd1,
                         vq[i].exp.ack0, vq[i].exp.ack1, vq[i].exp.mv, vq[i].exp.mwe, vq[i].exp.mre,
                         vq[i].exp.maddr, vq[i].exp.mwd, vq[i].exp.rd0, vq[i].exp.rd1);
            end
        end

        // Both ports holding read requests: acks must alternate 0,1,0,...
        // every 2 cycles starting 2 cycles after the request is first seen.
        drive(mk(1,0,0,0,0, 0,0, 0,0, 0,0,0,0,0, 0,0, 0,0));
        drive(mk(0,1,1,0,0, 1,2, 0,0, 0,0,0,0,0, 0,0, 0,0));
        begin
            int  nacks;
            int  last_cyc;
            logic exp_port;
            nacks = 0; last_cyc = 0; exp_port = 1'b0;
            for (int cyc = 0; cyc < 40 && nacks < 10; cyc++) begin
                if (cyc > 0) @(posedge i_clk);
                @(negedge i_clk);
                if (o_ack0 || o_ack1) begin
                    checks++;
                    if ((o_ack0 && o_ack1) || (o_ack1 != exp_port) ||
                        (cyc != ((nacks == 0) ? 2 : last_cyc + 2)) ||
                        (!exp_port && o_rdata0 !== 32'd1) ||
                        (exp_port && o_rdata1 !== 32'd2)) begin
                        failures++;
                        $display("FAIL alt ack#%0d cyc=%0d got ack0=%0b ack1=%0b r0=%h r1=%h exp port=%0d cyc=%0d",
                                 nacks, cyc, o_ack0, o_ack1, o_rdata0, o_rdata1, exp_port,
                                 (nacks == 0) ? 2 : last_cyc + 2);
                    end
                    nacks++;
                    last_cyc = cyc;
                    exp_port = ~exp_port;
                end
            end
            checks++;
            if (nacks != 10) begin
                failures++;
                $display("FAIL alt_count got %0d acks required 10", nacks);
            end
        end
        drive(mk(0,0,0,0,0, 0,0, 0,0, 0,0,0,0,0, 0,0, 0,0));
        repeat (3) @(posedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
